// File: rtl/rv_mem_pkg.sv
// -----------------------------------------------------------------------------
// rv_mem_pkg
// Shared types and helpers for the memory-access stage and its consumers.
//   mem_size_e  : funct3 access-size encodings (B, H, W, BU, HU).
//   mem_state_e : memory-access FSM states.
//   BYTE_LANES  : byte lanes per data word.
//   store_be / store_wdata / is_misaligned : store lane steering and the
//   alignment test used by the optional misaligned-access trap.
// Size codes outside the five legal encodings decode as a full word.
// -----------------------------------------------------------------------------
package rv_mem_pkg;

  localparam int MEM_DATA_WIDTH = 32;
  localparam int BYTE_LANES     = MEM_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_e;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2
  } mem_state_e;

  function automatic logic [BYTE_LANES-1:0] store_be(input logic [2:0] size,
                                                      input logic [1:0] offset);
    logic [BYTE_LANES-1:0] be;
    case (size)
      MEM_B, MEM_BU: be = 4'b0001 << offset;
      MEM_H, MEM_HU: be = 4'b0011 << {offset[1], 1'b0};
      default:       be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the operand into every lane it could land in so the byte
  // enables alone select the target bytes.
  function automatic logic [MEM_DATA_WIDTH-1:0] store_wdata(input logic [2:0] size,
                                                           input logic [MEM_DATA_WIDTH-1:0] data);
    logic [MEM_DATA_WIDTH-1:0] wdata;
    case (size)
      MEM_B, MEM_BU: wdata = {4{data[7:0]}};
      MEM_H, MEM_HU: wdata = {2{data[15:0]}};
      default:       wdata = data;
    endcase
    return wdata;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] size,
                                         input logic [1:0] offset);
    logic mis;
    case (size)
      MEM_B, MEM_BU: mis = 1'b0;
      MEM_H, MEM_HU: mis = offset[0];
      default:       mis = (offset != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// -----------------------------------------------------------------------------
// mem_load_align
// Combinational load-data extraction: selects the byte or halfword at the
// access offset within the returned word and sign- (B, H) or zero- (BU, HU)
// extends it; word and unsupported sizes pass the word through. Also used by
// write-back forwarding.
// Ports:
//   i_rdata  : word returned by data memory
//   i_offset : address bits [1:0] of the access
//   i_size   : funct3 access size
//   o_data   : aligned, extended load result
// -----------------------------------------------------------------------------
module mem_load_align
  import rv_mem_pkg::*;
(
  input  logic [MEM_DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]                i_offset,
  input  logic [2:0]                i_size,
  output logic [MEM_DATA_WIDTH-1:0] o_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_ext;

  assign byte_sel = i_rdata[{i_offset, 3'b000} +: 8];
  assign half_sel = i_rdata[{i_offset[1], 4'b0000} +: 16];
  // funct3[2] marks the unsigned variants.
  assign sign_ext = ~i_size[2];

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves o_data unassigned (which would infer a latch).
    o_data = i_rdata;
    case (i_size)
      MEM_B, MEM_BU: o_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      MEM_H, MEM_HU: o_data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default:       o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/i_memory_access.sv
// -----------------------------------------------------------------------------
// i_memory_access
// Memory-access stage of the five-stage RISC-V pipeline. Non-memory ops pass
// the ALU result to write-back in one cycle; loads and stores run a
// request/response handshake with data memory while stalling upstream.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned H/W accesses issue
// no request and are flagged on o_IM_misaligned).
// Ports:
//   i_clk, i_reset_n            : clock, asynchronous active-low reset
//   i_IE_*, i_ctrl_*            : instruction from execute
//   o_stall                     : upstream must hold while an access is open
//   o_dmem_req/we/addr/wdata/be : registered memory request, held until ready
//   i_dmem_ready                : memory accepts the request
//   i_dmem_rvalid/rdata         : load response
//   o_IM_valid/result/rd_addr   : one registered result pulse per instruction
//   o_IM_misaligned             : misaligned flag (MEM_MISALIGN_TRAP_EN only)
// -----------------------------------------------------------------------------
module i_memory_access
  import rv_mem_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int REG_FILE_DEPTH = 32,
  localparam int REG_FILE_ADDR  = $clog2(REG_FILE_DEPTH)
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_IE_valid,
  input  logic [DATA_WIDTH-1:0]     i_IE_result,
  input  logic [DATA_WIDTH-1:0]     i_IE_data_write,
  input  logic                      i_ctrl_mem_read,
  input  logic                      i_ctrl_mem_write,
  input  logic [2:0]                i_ctrl_mem_size,
  input  logic [REG_FILE_ADDR-1:0]  i_ctrl_rd_addr,
  output logic                      o_stall,
  output logic                      o_dmem_req,
  input  logic                      i_dmem_ready,
  output logic                      o_dmem_we,
  output logic [DATA_WIDTH-1:0]     o_dmem_addr,
  output logic [DATA_WIDTH-1:0]     o_dmem_wdata,
  output logic [DATA_WIDTH/8-1:0]   o_dmem_be,
  input  logic                      i_dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]     i_dmem_rdata,
  output logic                      o_IM_valid,
  output logic [DATA_WIDTH-1:0]     o_IM_result,
  output logic [REG_FILE_ADDR-1:0]  o_IM_rd_addr
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                      o_IM_misaligned
`endif
);

  mem_state_e               state, next_state;
  logic                     is_mem;
  logic                     trap;
  logic [2:0]               size_q;
  logic [1:0]               offset_q;
  logic [REG_FILE_ADDR-1:0] rd_q;
  logic [DATA_WIDTH-1:0]    load_data;

  assign is_mem  = i_ctrl_mem_read | i_ctrl_mem_write;
  assign o_stall = (state != MEM_IDLE);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = is_misaligned(i_ctrl_mem_size, i_IE_result[1:0]);
`else
  assign trap = 1'b0;
`endif

  mem_load_align u_load_align (
    .i_rdata  (i_dmem_rdata),
    .i_offset (offset_q),
    .i_size   (size_q),
    .o_data   (load_data)
  );

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= MEM_IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      MEM_IDLE: if (i_IE_valid && is_mem && !trap) next_state = MEM_REQ;
      MEM_REQ:  if (i_dmem_ready) next_state = o_dmem_we ? MEM_IDLE : MEM_WAIT;
      MEM_WAIT: if (i_dmem_rvalid) next_state = MEM_IDLE;
      default:  next_state = MEM_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_wdata <= '0;
      o_dmem_be    <= '0;
      o_IM_valid   <= 1'b0;
      o_IM_result  <= '0;
      o_IM_rd_addr <= '0;
      size_q       <= '0;
      offset_q     <= '0;
      rd_q         <= '0;
    end else begin
      o_IM_valid <= 1'b0;
      case (state)
        MEM_IDLE: begin
          if (i_IE_valid) begin
            if (!is_mem || trap) begin
              o_IM_valid   <= 1'b1;
              o_IM_result  <= trap ? '0 : i_IE_result;
              o_IM_rd_addr <= i_ctrl_rd_addr;
            end else begin
              // A store wins when both read and write are set.
              o_dmem_req   <= 1'b1;
              o_dmem_we    <= i_ctrl_mem_write;
              o_dmem_addr  <= {i_IE_result[DATA_WIDTH-1:2], 2'b00};
              o_dmem_wdata <= store_wdata(i_ctrl_mem_size, i_IE_data_write);
              o_dmem_be    <= i_ctrl_mem_write ? store_be(i_ctrl_mem_size, i_IE_result[1:0])
                                               : 4'b1111;
              size_q       <= i_ctrl_mem_size;
              offset_q     <= i_IE_result[1:0];
              rd_q         <= i_ctrl_rd_addr;
            end
          end
        end
        MEM_REQ: begin
          if (i_dmem_ready) begin
            o_dmem_req <= 1'b0;
            if (o_dmem_we) begin
              o_IM_valid   <= 1'b1;
              o_IM_result  <= '0;
              o_IM_rd_addr <= rd_q;
            end
          end
        end
        MEM_WAIT: begin
          if (i_dmem_rvalid) begin
            o_IM_valid   <= 1'b1;
            o_IM_result  <= load_data;
            o_IM_rd_addr <= rd_q;
          end
        end
        default: o_dmem_req <= 1'b0;
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) o_IM_misaligned <= 1'b0;
    else            o_IM_misaligned <= (state == MEM_IDLE) && i_IE_valid && is_mem && trap;
  end
`endif

endmodule

// File: tb/tb_i_memory_access.sv
// -----------------------------------------------------------------------------
// tb_i_memory_access
// Directed self-checking bench for i_memory_access with hand-computed
// expected values. Follows MEM_MISALIGN_TRAP_EN for the misaligned-word case.
// -----------------------------------------------------------------------------
module tb_i_memory_access;
  import rv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ie_valid;
  logic [31:0] ie_result;
  logic [31:0] ie_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_size;
  logic [4:0]  rd_addr;
  logic        stall;
  logic        dmem_req;
  logic        dmem_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        im_valid;
  logic [31:0] im_result;
  logic [4:0]  im_rd_addr;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        im_misaligned;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i_memory_access dut (
    .i_clk            (clk),
    .i_reset_n        (rst_n),
    .i_IE_valid       (ie_valid),
    .i_IE_result      (ie_result),
    .i_IE_data_write  (ie_data),
    .i_ctrl_mem_read  (mem_read),
    .i_ctrl_mem_write (mem_write),
    .i_ctrl_mem_size  (mem_size),
    .i_ctrl_rd_addr   (rd_addr),
    .o_stall          (stall),
    .o_dmem_req       (dmem_req),
    .i_dmem_ready     (dmem_ready),
    .o_dmem_we        (dmem_we),
    .o_dmem_addr      (dmem_addr),
    .o_dmem_wdata     (dmem_wdata),
    .o_dmem_be        (dmem_be),
    .i_dmem_rvalid    (dmem_rvalid),
    .i_dmem_rdata     (dmem_rdata),
    .o_IM_valid       (im_valid),
    .o_IM_result      (im_result),
    .o_IM_rd_addr     (im_rd_addr)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .o_IM_misaligned  (im_misaligned)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] size, input logic [4:0] rd, input int ready_dly,
                          input logic both, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    ie_valid = 1'b1; ie_result = addr; ie_data = data;
    mem_write = 1'b1; mem_read = both; mem_size = size; rd_addr = rd;
    tick();
    // A different non-memory op is offered while stalled; it must be ignored.
    mem_write = 1'b0; mem_read = 1'b0; ie_result = 32'h0000_0999; rd_addr = 5'd31;
    check({tag, " req"},   32'(dmem_req), 1);
    check({tag, " we"},    32'(dmem_we), 1);
    check({tag, " addr"},  dmem_addr, {addr[31:2], 2'b00});
    check({tag, " be"},    32'(dmem_be), 32'(exp_be));
    check({tag, " wdata"}, dmem_wdata, exp_wdata);
    check({tag, " stall"}, 32'(stall), 1);
    for (int i = 0; i < ready_dly; i++) begin
      tick();
      check({tag, " req held"}, 32'(dmem_req), 1);
      check({tag, " be held"},  32'(dmem_be), 32'(exp_be));
      check({tag, " no valid"}, 32'(im_valid), 0);
    end
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0; ie_valid = 1'b0;
    check({tag, " done valid"},  32'(im_valid), 1);
    check({tag, " done result"}, im_result, 0);
    check({tag, " done rd"},     32'(im_rd_addr), 32'(rd));
    check({tag, " req drop"},    32'(dmem_req), 0);
    check({tag, " stall drop"},  32'(stall), 0);
    tick();
    check({tag, " pulse"}, 32'(im_valid), 0);
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] size,
                         input logic [4:0] rd, input int ready_dly, input int rvalid_dly,
                         input logic [31:0] rdata, input logic [31:0] exp);
    ie_valid = 1'b1; ie_result = addr; ie_data = 32'h5555_5555;
    mem_read = 1'b1; mem_write = 1'b0; mem_size = size; rd_addr = rd;
    tick();
    ie_valid = 1'b0; mem_read = 1'b0; ie_result = 32'hFFFF_FFFF;
    check({tag, " req"},   32'(dmem_req), 1);
    check({tag, " we"},    32'(dmem_we), 0);
    check({tag, " addr"},  dmem_addr, {addr[31:2], 2'b00});
    check({tag, " be"},    32'(dmem_be), 32'hF);
    check({tag, " stall"}, 32'(stall), 1);
    for (int i = 0; i < ready_dly; i++) begin
      tick();
      check({tag, " req held"},  32'(dmem_req), 1);
      check({tag, " addr held"}, dmem_addr, {addr[31:2], 2'b00});
      check({tag, " stall req"}, 32'(stall), 1);
    end
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    check({tag, " wait req"},   32'(dmem_req), 0);
    check({tag, " wait stall"}, 32'(stall), 1);
    check({tag, " wait valid"}, 32'(im_valid), 0);
    for (int i = 0; i < rvalid_dly; i++) begin
      tick();
      check({tag, " stall wait"}, 32'(stall), 1);
      check({tag, " no valid"},   32'(im_valid), 0);
    end
    dmem_rvalid = 1'b1; dmem_rdata = rdata;
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    check({tag, " valid"},  32'(im_valid), 1);
    check({tag, " result"}, im_result, exp);
    check({tag, " rd"},     32'(im_rd_addr), 32'(rd));
    check({tag, " stall"},  32'(stall), 0);
`ifdef MEM_MISALIGN_TRAP_EN
    check({tag, " aligned"}, 32'(im_misaligned), 0);
`endif
    tick();
    check({tag, " pulse"}, 32'(im_valid), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    ie_valid = 1'b0; ie_result = '0; ie_data = '0;
    mem_read = 1'b0; mem_write = 1'b0; mem_size = '0; rd_addr = '0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst stall",  32'(stall), 0);
    check("rst req",    32'(dmem_req), 0);
    check("rst we",     32'(dmem_we), 0);
    check("rst valid",  32'(im_valid), 0);
    check("rst result", im_result, 0);
    check("rst addr",   dmem_addr, 0);
    check("rst be",     32'(dmem_be), 0);
    check("rst wdata",  dmem_wdata, 0);
    check("rst rd",     32'(im_rd_addr), 0);
    rst_n = 1'b1;
    tick();

    // Non-memory op, then two back-to-back.
    ie_valid = 1'b1; ie_result = 32'h1234_5678; rd_addr = 5'd5;
    tick();
    check("alu valid",  32'(im_valid), 1);
    check("alu result", im_result, 32'h1234_5678);
    check("alu rd",     32'(im_rd_addr), 5);
    check("alu stall",  32'(stall), 0);
    ie_result = 32'hCAFE_0001; rd_addr = 5'd6;
    tick();
    check("b2b valid",  32'(im_valid), 1);
    check("b2b result", im_result, 32'hCAFE_0001);
    check("b2b rd",     32'(im_rd_addr), 6);
    check("b2b stall",  32'(stall), 0);
    ie_valid = 1'b0;
    tick();
    check("alu pulse", 32'(im_valid), 0);

    // Stores.
    do_store("sb",    32'h0000_0103, 32'h0000_00AB, MEM_B, 5'd3, 0, 1'b0, 4'b1000, 32'hABAB_ABAB);
    do_store("sh",    32'h0000_0006, 32'h1234_BEEF, MEM_H, 5'd4, 2, 1'b0, 4'b1100, 32'hBEEF_BEEF);
    do_store("sw",    32'h0000_0008, 32'hDEAD_BEEF, MEM_W, 5'd8, 1, 1'b0, 4'b1111, 32'hDEAD_BEEF);
    do_store("sw_rw", 32'h0000_0020, 32'h0BAD_F00D, MEM_W, 5'd2, 0, 1'b1, 4'b1111, 32'h0BAD_F00D);

    // Loads.
    do_load("lb",   32'h0000_0202, MEM_B,  5'd7,  0, 0, 32'h0080_0000, 32'hFFFF_FF80);
    do_load("lbu",  32'h0000_0202, MEM_BU, 5'd7,  0, 0, 32'h0080_0000, 32'h0000_0080);
    do_load("lbu1", 32'h0000_0031, MEM_BU, 5'd10, 0, 1, 32'h0000_9A00, 32'h0000_009A);
    do_load("lb0",  32'h0000_0040, MEM_B,  5'd11, 1, 0, 32'hFFFF_FF7F, 32'h0000_007F);
    do_load("lh",   32'h0000_0002, MEM_H,  5'd12, 3, 2, 32'h8001_0000, 32'hFFFF_8001);
    do_load("lhu",  32'h0000_0000, MEM_HU, 5'd13, 0, 0, 32'h1234_F00D, 32'h0000_F00D);
    do_load("lw",   32'h0000_000C, MEM_W,  5'd14, 0, 0, 32'h8765_4321, 32'h8765_4321);
    do_load("l111", 32'h0000_0010, 3'b111, 5'd15, 0, 0, 32'hA5A5_0F0F, 32'hA5A5_0F0F);

    // A stray rvalid while idle produces nothing.
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
    tick();
    dmem_rvalid = 1'b0;
    check("idle rvalid valid", 32'(im_valid), 0);
    check("idle rvalid stall", 32'(stall), 0);

    // Reset while a request is pending drops req without waiting for a clock.
    ie_valid = 1'b1; ie_result = 32'h0000_0100; mem_read = 1'b1; mem_size = MEM_W; rd_addr = 5'd1;
    tick();
    ie_valid = 1'b0; mem_read = 1'b0;
    check("rstreq req before", 32'(dmem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstreq req", 32'(dmem_req), 0);
    check("rstreq stall", 32'(stall), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset during WAIT; the late response after release is ignored.
    ie_valid = 1'b1; ie_result = 32'h0000_0104; mem_read = 1'b1; mem_size = MEM_W; rd_addr = 5'd2;
    tick();
    ie_valid = 1'b0; mem_read = 1'b0;
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    check("rstwait in wait", 32'(stall), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstwait stall", 32'(stall), 0);
    tick();
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h2222_2222;
    tick();
    dmem_rvalid = 1'b0;
    check("rstwait valid", 32'(im_valid), 0);
    check("rstwait req",   32'(dmem_req), 0);
    check("rstwait idle",  32'(stall), 0);
    tick();
    check("rstwait valid2", 32'(im_valid), 0);

    // Misaligned word load.
`ifdef MEM_MISALIGN_TRAP_EN
    ie_valid = 1'b1; ie_result = 32'h0000_0006; mem_read = 1'b1; mem_size = MEM_W; rd_addr = 5'd9;
    tick();
    ie_valid = 1'b0; mem_read = 1'b0;
    check("lw_mis req",    32'(dmem_req), 0);
    check("lw_mis stall",  32'(stall), 0);
    check("lw_mis valid",  32'(im_valid), 1);
    check("lw_mis flag",   32'(im_misaligned), 1);
    check("lw_mis result", im_result, 0);
    check("lw_mis rd",     32'(im_rd_addr), 9);
    tick();
    check("lw_mis pulse", 32'(im_valid), 0);
    check("lw_mis flag pulse", 32'(im_misaligned), 0);
`else
    do_load("lw_mis", 32'h0000_0006, MEM_W, 5'd9, 0, 0, 32'h1122_3344, 32'h1122_3344);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
